// File: rtl/fft_addr_gen_if.sv
// ---------------------------------------------------------------------------
// fft_addr_gen_if
// Handshake and address bus between the FFT address sequencer and its users
// (top-level FFT control, data RAM, butterfly unit, twiddle ROM).
//   Start      : request one full FFT (control -> sequencer)
//   Ready      : butterfly unit accepts the presented operand set
//   Valid      : Addr_A / Addr_B / Tw_Address / Stage describe a butterfly
//   Addr_A     : upper-leg data RAM address
//   Addr_B     : lower-leg data RAM address
//   Tw_Address : twiddle ROM index, zero-extended
//   Stage      : stage index of the presented (or upcoming) butterfly
//   Busy       : FFT in progress
//   Done       : one-cycle pulse after the last butterfly is accepted
// Modport slave is the sequencer side, master is the control/consumer side.
// ---------------------------------------------------------------------------
interface fft_addr_gen_if #(
    parameter int LOG2_NFFT  = 5,
    parameter int DATA_WIDTH = 16
);
    localparam int STAGE_W = (LOG2_NFFT > 1) ? $clog2(LOG2_NFFT) : 1;

    logic                  Start;
    logic                  Ready;
    logic                  Valid;
    logic [LOG2_NFFT-1:0]  Addr_A;
    logic [LOG2_NFFT-1:0]  Addr_B;
    logic [DATA_WIDTH-1:0] Tw_Address;
    logic [STAGE_W-1:0]    Stage;
    logic                  Busy;
    logic                  Done;

    modport slave (
        input  Start, Ready,
        output Valid, Addr_A, Addr_B, Tw_Address, Stage, Busy, Done
    );

    modport master (
        output Start, Ready,
        input  Valid, Addr_A, Addr_B, Tw_Address, Stage, Busy, Done
    );
endinterface

// File: rtl/fft_addr_gen.sv
// ---------------------------------------------------------------------------
// fft_addr_gen
// Address sequencer for an in-place radix-2 DIT FFT of 2**LOG2_NFFT points.
// After Start it walks stage s = 0..LOG2_NFFT-1 and butterfly
// k = 0..N/2-1, presenting per butterfly the two data RAM operand addresses
// and the twiddle ROM index. Transfers happen on Valid && Ready; STAGE_GAP
// idle cycles separate consecutive stages so the butterfly pipeline can
// write back before the next stage reads.
// Ports:
//   CLK : clock, all state on rising edge
//   RST : asynchronous active-low reset
//   bus : fft_addr_gen_if.slave (Start, Ready in; Valid, Addr_A, Addr_B,
//         Tw_Address, Stage, Busy, Done out -- all outputs registered)
// ---------------------------------------------------------------------------
module fft_addr_gen #(
    parameter int LOG2_NFFT  = 5,
    parameter int DATA_WIDTH = 16,
    parameter int STAGE_GAP  = 3
) (
    input  logic           CLK,
    input  logic           RST,
    fft_addr_gen_if.slave  bus
);
    localparam int N_HALF = 2 ** (LOG2_NFFT - 1);
    localparam int SW     = (LOG2_NFFT > 1) ? $clog2(LOG2_NFFT) : 1;
    localparam int KW     = (LOG2_NFFT > 1) ? (LOG2_NFFT - 1) : 1;
    localparam int GW     = (STAGE_GAP > 1) ? $clog2(STAGE_GAP + 1) : 1;

    localparam logic [LOG2_NFFT-1:0] ONE_L  = {{(LOG2_NFFT-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0]        LAST_S = SW'(LOG2_NFFT - 1);
    localparam logic [KW-1:0]        LAST_K = KW'(N_HALF - 1);
    localparam logic [GW-1:0]        GAP_LD = GW'(STAGE_GAP);
    localparam logic [GW-1:0]        GAP_1  = GW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t                state_q,  state_d;
    logic [SW-1:0]         s_q,      s_d;
    logic [KW-1:0]         k_q,      k_d;
    logic [GW-1:0]         gap_q,    gap_d;
    logic                  valid_q,  valid_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;
    logic [LOG2_NFFT-1:0]  addr_a_q, addr_a_d;
    logic [LOG2_NFFT-1:0]  addr_b_q, addr_b_d;
    logic [DATA_WIDTH-1:0] tw_q,     tw_d;
    logic                  load_s;

    // Butterfly span 2**s: distance between the two legs of a butterfly.
    function automatic logic [LOG2_NFFT-1:0] calc_span(input logic [SW-1:0] s);
        calc_span = ONE_L << s;
    endfunction

    // Upper-leg address: group index scaled by 2*span plus position in group.
    function automatic logic [LOG2_NFFT-1:0] calc_addr_a(input logic [SW-1:0] s,
                                                         input logic [KW-1:0] k);
        logic [LOG2_NFFT-1:0] kx;
        logic [LOG2_NFFT-1:0] pos;
        logic [LOG2_NFFT-1:0] grp;
        kx          = LOG2_NFFT'(k);
        pos         = kx & (calc_span(s) - ONE_L);
        grp         = kx >> s;
        calc_addr_a = ((grp << s) << 1'b1) | pos;
    endfunction

    // Twiddle index: position in group scaled up to the N-point root table.
    function automatic logic [DATA_WIDTH-1:0] calc_tw(input logic [SW-1:0] s,
                                                      input logic [KW-1:0] k);
        logic [LOG2_NFFT-1:0] pos;
        logic [SW-1:0]        sh;
        pos     = LOG2_NFFT'(k) & (calc_span(s) - ONE_L);
        sh      = LAST_S - s;
        calc_tw = DATA_WIDTH'(pos << sh);
    endfunction

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        k_d      = k_q;
        gap_d    = gap_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        load_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    state_d = ST_RUN;
                    s_d     = '0;
                    k_d     = '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    load_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (valid_q && bus.Ready) begin
                    if (k_q != LAST_K) begin
                        k_d    = k_q + KW'(1);
                        load_s = 1'b1;
                    end else if (s_q != LAST_S) begin
                        k_d    = '0;
                        s_d    = s_q + SW'(1);
                        load_s = 1'b1;
                        // With no gap the first butterfly of the next stage
                        // follows back-to-back.
                        if (STAGE_GAP > 0) begin
                            state_d = ST_GAP;
                            valid_d = 1'b0;
                            gap_d   = GAP_LD;
                        end else begin
                            valid_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_FIN;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_GAP: begin
                // Leave on the last counted idle cycle so Valid stays low
                // for exactly STAGE_GAP cycles.
                if (gap_q <= GAP_1) begin
                    state_d = ST_RUN;
                    gap_d   = '0;
                    valid_d = 1'b1;
                end else begin
                    gap_d = gap_q - GAP_1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        if (load_s) begin
            addr_a_d = calc_addr_a(s_d, k_d);
            addr_b_d = calc_addr_a(s_d, k_d) | calc_span(s_d);
            tw_d     = calc_tw(s_d, k_d);
        end else begin
            addr_a_d = addr_a_q;
            addr_b_d = addr_b_q;
            tw_d     = tw_q;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            s_q      <= '0;
            k_q      <= '0;
            gap_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            k_q      <= k_d;
            gap_q    <= gap_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            tw_q     <= tw_d;
        end
    end

    assign bus.Valid      = valid_q;
    assign bus.Busy       = busy_q;
    assign bus.Done       = done_q;
    assign bus.Addr_A     = addr_a_q;
    assign bus.Addr_B     = addr_b_q;
    assign bus.Tw_Address = tw_q;
    assign bus.Stage      = s_q;
endmodule

// File: doc/fft_addr_gen.md
Name: fft_addr_gen

Overview:
Sequencer for an in-place radix-2 DIT FFT of 2**LOG2_NFFT points. On Start it walks every stage and butterfly and issues per butterfly the two data-memory operand addresses plus the twiddle ROM address. It sits between the top-level FFT control, the data RAM and the butterfly unit, and drives the Address input of the twiddle ROM directly. Input data is already in bit-reversed order in RAM; reordering is outside this block.

Parameters:
LOG2_NFFT, 5, log2 of FFT points N (N = 2**LOG2_NFFT; N/2 butterflies per stage, LOG2_NFFT stages)
DATA_WIDTH, 16, width of twiddle ROM address bus
STAGE_GAP, 3, idle cycles inserted between stages to cover butterfly pipeline write-back latency (0 allowed)

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  asynchronous active-low reset
Start  input  1  request one full FFT; sampled only in IDLE
Ready  input  1  butterfly unit accepts the current operand set
Valid  output  1  Addr_A/Addr_B/Tw_Address/Stage hold a valid butterfly
Addr_A  output  LOG2_NFFT  upper-leg data RAM address
Addr_B  output  LOG2_NFFT  lower-leg data RAM address
Tw_Address  output  DATA_WIDTH  twiddle ROM index, zero-extended
Stage  output  ceil(log2(LOG2_NFFT)) min 1  current stage index s
Busy  output  1  high from Start acceptance until Done
Done  output  1  one-cycle pulse after last butterfly accepted

Behaviour:
- Reset (RST low, async): state IDLE; Valid, Busy, Done = 0; Addr_A, Addr_B, Tw_Address, Stage = 0; counters s, k, gap = 0. Reset mid-FFT aborts immediately, no Done.
- All outputs registered.
- States: IDLE, RUN, GAP, FIN.
- IDLE: Start=1 -> RUN, s=0, k=0, Busy=1, Valid=1 next cycle with butterfly (0,0). Start=0 -> stay.
- RUN: Valid=1. Transfer occurs when Valid && Ready. No transfer: all outputs hold unchanged. On transfer:
  - k < N/2-1: k+1, stay RUN.
  - k = N/2-1 and s < LOG2_NFFT-1: k=0, s+1; STAGE_GAP>0 -> GAP with Valid=0, gap counter = STAGE_GAP; STAGE_GAP=0 -> stay RUN, next butterfly presented the next cycle.
  - k = N/2-1 and s = LOG2_NFFT-1: -> FIN, Valid=0.
- GAP: Valid=0, decrement gap each cycle; Ready ignored; after exactly STAGE_GAP cycles -> RUN presenting (s, 0).
- FIN: Done=1 for one cycle, Busy=0 same cycle, -> IDLE. Start during FIN ignored.
- Start while Busy ignored (no restart, no queue).
- Address arithmetic for stage s, butterfly k (span = 2**s):
  - pos = k mod span; grp = k >> s
  - Addr_A = grp*2*span + pos; Addr_B = Addr_A + span (both fit LOG2_NFFT bits, no wrap)
  - Tw_Address = pos << (LOG2_NFFT-1-s), i.e. W_N^idx, idx in 0..N/2-1
- Throughput with Ready held high: total cycles Start-accept to Done = LOG2_NFFT*N/2 + (LOG2_NFFT-1)*STAGE_GAP + 1.
- Stage output equals s of the presented butterfly; in GAP shows the upcoming stage.

Test Plan:
- Reset: assert RST low mid-RUN (s=2, k=7) -> all outputs 0 asynchronously, IDLE; after release no Done, Valid=0 until new Start.
- Full run, defaults, Ready=1: Start pulse -> first Valid cycle (A=0,B=1,Tw=0); stage 0 k=1 (2,3,0); stage 1 k=1 (1,3,8); stage 2 k=5 (9,13,4); stage 4 k=5 (5,21,5); Done after exactly 5*16+4*3+1=93 cycles; 80 transfers total.
- Gap check: at each stage boundary Valid low for exactly 3 cycles; repeat with STAGE_GAP=0 -> no bubble, 81 cycles.
- Backpressure: drop Ready for 4 cycles at stage 3 k=10 -> outputs hold (A=18, B=26, Tw=4, Stage=3); resume yields k=11 next; no butterfly skipped or duplicated (scoreboard all 80 triples against reference model).
- Start while Busy: pulse Start at stage 1 -> ignored, sequence and Done timing unchanged; Start in the Done cycle ignored; Start the cycle after -> new run.
- Parameter sweep LOG2_NFFT=3 (N=8): stage 2 butterflies (0,4,0),(1,5,1),(2,6,2),(3,7,3); Done after 3*4+2*3+1=19 cycles.
